// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
// -----------------
// Sequencing controller for a bit-serial Moore 10010 detector. A WIDTH-bit
// word is accepted through a start/busy handshake, the detector is cleared
// for one cycle, and the word is then fed to it MSB first, one bit per
// clock. Detector output assertions are counted. When the scan is complete,
// the count is reported together with a one-cycle done pulse.
//
// Handshake: start is sampled only while busy=0 (IDLE). A start seen with
// abort=0 on a rising edge is accepted on that edge, and din is captured on
// the same edge. busy rises on that edge. A start seen while busy=1 is
// dropped, not queued. The producer may present the next word as soon as it
// sees busy=0.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      scan request (sampled only in IDLE)
//   din        word to scan, captured on the accepting edge
//   abort      cancel the current scan; blocks start while in IDLE
//   busy       high in every state except IDLE
//   det_rst    active-low detector reset, low only in CLR
//   det_j      serial bit to the detector
//   det_w      detector Moore output
//   done       one-cycle pulse, scan complete
//   match_cnt  matches found in the last completed scan (saturating)
//   dbg_state  current FSM state, for observation only

module pattern_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             abort,
  output logic             busy,
  output logic             det_rst,
  output logic             det_j,
  input  logic             det_w,
  output logic             done,
  output logic [CNTW-1:0]  match_cnt,
  output logic [2:0]       dbg_state
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             cnt_en;

  assign accept = (state == IDLE) && start && !abort;

  // The detector was cleared during CLR. Its output in the first SHIFT cycle
  // therefore carries no information. The last bit's match becomes visible
  // only one cycle later, in DRAIN.
  assign cnt_en = ((state == SHIFT) && (idx != '0)) || (state == DRAIN);

  assign dbg_state = state;

  // State register and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      idx       <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_nx;

      if (accept) begin
        sreg <= din;
      end else if (state == SHIFT) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end

      if (state == CLR) begin
        idx <= '0;
      end else if (state == SHIFT) begin
        idx <= idx + IW'(1);
      end

      // An abort outside IDLE discards the partial count. A new accept
      // starts the count from zero. Otherwise, the count saturates.
      if (accept || ((state != IDLE) && abort)) begin
        match_cnt <= '0;
      end else if (cnt_en && det_w && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + CNTW'(1);
      end
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    det_rst  = 1'b1;
    det_j    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nx = CLR;
      end
      CLR: begin
        det_rst  = 1'b0;
        state_nx = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        det_j = sreg[WIDTH-1];
        if (abort)                state_nx = IDLE;
        else if (idx == LAST_IDX) state_nx = DRAIN;
      end
      DRAIN: begin
        state_nx = abort ? IDLE : DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
